// File: rtl/patch_mult_pkg.sv
// Shared types and default sizing for the patch-multiplier sequencer.
// Default index width is derived from the patch length.
package patch_mult_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_PATCH_LEN = 81;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_IDX_W     = clog2(DEF_PATCH_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        RUN,
        DRAIN,
        PUSH
    } state_t;

endpackage

// File: rtl/patch_coef_ram.sv
// Kernel coefficient store: one write port, one registered read port.
// Contents are not reset; only written entries are ever read.
module patch_coef_ram
#(
    parameter int DEPTH = 81,
    parameter int W     = 32,
    parameter int AW    = 7
)
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/patch_mult_sequencer.sv
// Loads a kernel, streams patches through an external MAC and
// pushes one accumulated result per patch into the read FIFO.
module patch_mult_sequencer
    import patch_mult_pkg::*;
#(
    parameter int PATCH_LEN = DEF_PATCH_LEN,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IDX_W     = DEF_IDX_W
)
(
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic              kernel_empty,
    output logic              kernel_rden,
    input  logic [DATA_W-1:0] kernel_data,
    input  logic              kernel_open,
    input  logic              patch_empty,
    output logic              patch_rden,
    input  logic [DATA_W-1:0] patch_data,
    input  logic              patch_open,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic              mac_res_valid,
    input  logic [DATA_W-1:0] mac_res,
    input  logic              res_full,
    output logic              res_wren,
    output logic [DATA_W-1:0] res_data,
    output logic              kernel_loaded,
    output logic              busy,
    output logic              abort_pulse
);

    localparam logic [IDX_W:0]   LEN    = (IDX_W+1)'(PATCH_LEN);
    localparam logic [IDX_W:0]   LAST_P = (IDX_W+1)'(PATCH_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(PATCH_LEN - 1);

    state_t            state;
    logic [IDX_W-1:0]  k_idx;
    logic [IDX_W:0]    k_rd;
    logic [IDX_W:0]    p_rd;
    logic              k_vld;
    logic              mv_q;
    logic              mf_q;
    logic              ml_q;
    logic [DATA_W-1:0] coef_q;
    logic              k_done;

    // Read counters are one bit wider so PATCH_LEN itself is representable.
    assign kernel_rden = (state == LOAD_K) && !kernel_empty && (k_rd != LEN);
    assign patch_rden  = (state == RUN) && patch_open && !patch_empty
                         && (p_rd != LEN);
    assign res_wren    = (state == PUSH) && !res_full;
    assign busy        = (state != IDLE);
    assign k_done      = k_vld && (k_idx == LAST_K);

    assign mac_valid = mv_q;
    assign mac_first = mf_q;
    assign mac_last  = ml_q;
    assign mac_a     = mv_q ? patch_data : '0;
    assign mac_b     = mv_q ? coef_q : '0;

    patch_coef_ram #(
        .DEPTH (PATCH_LEN),
        .W     (DATA_W),
        .AW    (IDX_W)
    ) u_coef (
        .clk   (bus_clk),
        .we    (k_vld && (state == LOAD_K)),
        .waddr (k_idx),
        .wdata (kernel_data),
        .re    (patch_rden),
        .raddr (p_rd[IDX_W-1:0]),
        .rdata (coef_q)
    );

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state         <= IDLE;
            k_idx         <= '0;
            k_rd          <= '0;
            p_rd          <= '0;
            k_vld         <= 1'b0;
            mv_q          <= 1'b0;
            mf_q          <= 1'b0;
            ml_q          <= 1'b0;
            res_data      <= '0;
            kernel_loaded <= 1'b0;
            abort_pulse   <= 1'b0;
        end else begin
            k_vld       <= kernel_rden;
            mv_q        <= patch_rden;
            mf_q        <= patch_rden && (p_rd == '0);
            ml_q        <= patch_rden && (p_rd == LAST_P);
            abort_pulse <= 1'b0;
            if (kernel_rden) k_rd <= k_rd + 1'b1;
            if (patch_rden)  p_rd <= p_rd + 1'b1;

            unique case (state)
                IDLE: begin
                    if (!kernel_empty) begin
                        state         <= LOAD_K;
                        kernel_loaded <= 1'b0;
                        k_idx         <= '0;
                        k_rd          <= '0;
                    end else if (kernel_loaded && !patch_empty) begin
                        state <= RUN;
                        p_rd  <= '0;
                    end
                end
                LOAD_K: begin
                    if (k_vld) k_idx <= k_idx + 1'b1;
                    if (k_done) begin
                        kernel_loaded <= 1'b1;
                        state         <= IDLE;
                    end else if (!kernel_open) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (mv_q && ml_q) begin
                        state <= DRAIN;
                    end else if (!patch_open) begin
                        abort_pulse <= 1'b1;
                        state       <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mac_res_valid) begin
                        res_data <= mac_res;
                        state    <= PUSH;
                    end
                end
                PUSH: begin
                    if (!res_full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_patch_mult_sequencer.sv
// Randomized bench: FIFO and MAC environment models plus a
// sum-of-products scoreboard for patch_mult_sequencer.
module tb_patch_mult_sequencer;

    localparam int N = 81;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic        last;
    } pair_t;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic        kernel_empty = 1'b1;
    logic        kernel_rden;
    logic [31:0] kernel_data = '0;
    logic        kernel_open = 1'b1;
    logic        patch_empty = 1'b1;
    logic        patch_rden;
    logic [31:0] patch_data = '0;
    logic        patch_open = 1'b1;
    logic        mac_valid;
    logic        mac_first;
    logic        mac_last;
    logic [31:0] mac_a;
    logic [31:0] mac_b;
    logic        mac_res_valid = 1'b0;
    logic [31:0] mac_res = '0;
    logic        res_full = 1'b0;
    logic        res_wren;
    logic [31:0] res_data;
    logic        kernel_loaded;
    logic        busy;
    logic        abort_pulse;

    pair_t       exp_pairs[$];
    logic [31:0] exp_res[$];
    logic [31:0] kq[$];
    logic [31:0] pq[$];
    logic [31:0] kern[N];
    logic [31:0] pat[N];

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_res = 0;
    int   n_abort = 0;
    int   n_mac = 0;
    int   cyc = 0;
    int   t_last = 0;
    int   mac_lat = 3;
    int   cd = 0;
    bit   bp = 1'b0;
    bit   gap = 1'b0;
    bit   gap_tog = 1'b0;
    logic kr = 1'b0;
    logic pr = 1'b0;
    logic [31:0] acc = '0;
    logic [31:0] acc_done = '0;

    always #5 bus_clk = ~bus_clk;

    patch_mult_sequencer dut (
        .bus_clk       (bus_clk),
        .bus_rst       (bus_rst),
        .kernel_empty  (kernel_empty),
        .kernel_rden   (kernel_rden),
        .kernel_data   (kernel_data),
        .kernel_open   (kernel_open),
        .patch_empty   (patch_empty),
        .patch_rden    (patch_rden),
        .patch_data    (patch_data),
        .patch_open    (patch_open),
        .mac_valid     (mac_valid),
        .mac_first     (mac_first),
        .mac_last      (mac_last),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_res_valid (mac_res_valid),
        .mac_res       (mac_res),
        .res_full      (res_full),
        .res_wren      (res_wren),
        .res_data      (res_data),
        .kernel_loaded (kernel_loaded),
        .busy          (busy),
        .abort_pulse   (abort_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Standard (non-FWFT) FIFOs: data appears the cycle after a read.
    always begin
        @(negedge bus_clk);
        kr = kernel_rden;
        pr = patch_rden;
        @(posedge bus_clk);
        #1;
        if (kr && kq.size() > 0) kernel_data = kq.pop_front();
        if (pr && pq.size() > 0) patch_data = pq.pop_front();
        gap_tog = ~gap_tog;
        kernel_empty = (kq.size() == 0);
        patch_empty = (pq.size() == 0) || (gap && gap_tog);
    end

    // External MAC: result strobe mac_lat cycles after the last product.
    always begin
        @(posedge bus_clk);
        #1;
        mac_res_valid = 1'b0;
        if (bus_rst) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mac_res_valid = 1'b1;
                mac_res = acc_done;
            end
        end
    end

    always @(negedge bus_clk) begin
        pair_t p;
        cyc++;
        if (mac_valid) begin
            n_mac++;
            acc = (mac_first ? 32'd0 : acc) + mac_a * mac_b;
            if (mac_last) begin
                acc_done = acc;
                cd = mac_lat;
                t_last = cyc;
                bp = 1'b0;
            end
            if (exp_pairs.size() == 0) begin
                check("pair_extra", 64'(1), 64'(0));
            end else begin
                p = exp_pairs.pop_front();
                check("mac_a", 64'(mac_a), 64'(p.a));
                check("mac_b", 64'(mac_b), 64'(p.b));
                check("first_last", 64'({mac_first, mac_last}),
                      64'({p.first, p.last}));
            end
        end
        if (res_full) begin
            bp = 1'b1;
            check("wren_full", 64'(res_wren), 64'(0));
        end
        if (res_wren) begin
            n_res++;
            if (exp_res.size() == 0) begin
                check("res_extra", 64'(1), 64'(0));
            end else begin
                check("res_data", 64'(res_data), 64'(exp_res.pop_front()));
            end
            if (!bp) check("latency", 64'(cyc - t_last), 64'(mac_lat + 1));
        end
        if (abort_pulse) n_abort++;
    end

    task automatic send_kernel();
        for (int i = 0; i < N; i++) kq.push_back(kern[i]);
    endtask

    task automatic send_patch(input int n);
        pair_t       p;
        logic [31:0] sum;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            pq.push_back(pat[i]);
            p.a = pat[i];
            p.b = kern[i];
            p.first = (i == 0);
            p.last = (i == N - 1);
            exp_pairs.push_back(p);
            sum = sum + pat[i] * kern[i];
        end
        if (n == N) exp_res.push_back(sum);
    endtask

    task automatic wait_res(input int target, input int budget);
        int c;
        c = 0;
        while (n_res < target && c < budget) begin
            @(negedge bus_clk);
            c++;
        end
        check("res_count", 64'(n_res), 64'(target));
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, 64'({kernel_rden, patch_rden, mac_valid, mac_first,
                        mac_last, res_wren, kernel_loaded, busy,
                        abort_pulse}), 64'(0));
        check("zero_mac_a", 64'(mac_a), 64'(0));
        check("zero_mac_b", 64'(mac_b), 64'(0));
        check("zero_res_data", 64'(res_data), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge bus_clk);
        #1;
        bus_rst = 1'b1;
        @(posedge bus_clk);
        #2;
        kq.delete();
        pq.delete();
        exp_pairs.delete();
        exp_res.delete();
        @(negedge bus_clk);
        check_zero_outputs("mid_reset_outs");
        repeat (2) @(posedge bus_clk);
        #1;
        bus_rst = 1'b0;
    endtask

    task automatic rand_kern();
        for (int i = 0; i < N; i++) kern[i] = $urandom;
    endtask

    task automatic rand_pat();
        for (int i = 0; i < N; i++) pat[i] = $urandom;
    endtask

    initial begin
        int base;
        int m0;
        int a0;
        int c;

        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        check_zero_outputs("reset_outs");
        @(posedge bus_clk);
        #1;
        bus_rst = 1'b0;

        // Ramp kernel against an all-ones patch: sum of 1..81.
        mac_lat = 3;
        for (int i = 0; i < N; i++) begin
            kern[i] = 32'(i + 1);
            pat[i] = 32'd1;
        end
        send_kernel();
        send_patch(N);
        check("ramp_sum", 64'(exp_res[0]), 64'(3321));
        wait_res(1, 400);
        check("k_loaded", 64'(kernel_loaded), 64'(1));
        check("kq_drained", 64'(kq.size()), 64'(0));

        // Patch waits until a kernel is present.
        do_reset();
        rand_kern();
        rand_pat();
        mac_lat = int'($urandom_range(1, 5));
        send_patch(N);
        for (int i = 0; i < 30; i++) begin
            @(negedge bus_clk);
            check("no_patch_rd", 64'(patch_rden), 64'(0));
        end
        check("patch_held", 64'(pq.size()), 64'(N));
        base = n_res;
        send_kernel();
        wait_res(base + 1, 400);

        // Patch FIFO empty every other cycle.
        for (int i = 0; i < N; i++) begin
            kern[i] = 32'(i + 1);
            pat[i] = 32'd1;
        end
        gap = 1'b1;
        mac_lat = int'($urandom_range(1, 5));
        m0 = n_mac;
        base = n_res;
        send_kernel();
        send_patch(N);
        wait_res(base + 1, 600);
        check("gap_mac_count", 64'(n_mac - m0), 64'(N));
        gap = 1'b0;

        // Result FIFO full while the result is pending.
        rand_pat();
        mac_lat = int'($urandom_range(1, 5));
        base = n_res;
        @(posedge bus_clk);
        #1;
        res_full = 1'b1;
        send_patch(N);
        repeat (N + 20) @(posedge bus_clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge bus_clk);
            check("res_hold", 64'(res_data), 64'(exp_res[0]));
        end
        check("push_busy", 64'(busy), 64'(1));
        check("push_no_res", 64'(n_res), 64'(base));
        @(posedge bus_clk);
        #1;
        res_full = 1'b0;
        wait_res(base + 1, 20);
        repeat (5) @(negedge bus_clk);
        check("push_once", 64'(n_res), 64'(base + 1));

        // Abort after 40 words, then a full patch.
        rand_pat();
        mac_lat = int'($urandom_range(1, 5));
        base = n_res;
        a0 = n_abort;
        send_patch(40);
        c = 0;
        while (exp_pairs.size() > 0 && c < 300) begin
            @(negedge bus_clk);
            c++;
        end
        check("partial_pairs", 64'(exp_pairs.size()), 64'(0));
        repeat (3) @(posedge bus_clk);
        #1;
        patch_open = 1'b0;
        repeat (4) @(negedge bus_clk);
        check("abort_cnt", 64'(n_abort - a0), 64'(1));
        check("abort_idle", 64'(busy), 64'(0));
        check("abort_no_res", 64'(n_res), 64'(base));
        @(posedge bus_clk);
        #1;
        patch_open = 1'b1;
        rand_pat();
        send_patch(N);
        wait_res(base + 1, 400);

        // Reset mid-RUN, reset mid-LOAD_K, then a full reload.
        rand_pat();
        send_patch(N);
        repeat (30) @(posedge bus_clk);
        #1;
        check("run_busy", 64'(busy), 64'(1));
        do_reset();
        rand_kern();
        send_kernel();
        repeat (30) @(posedge bus_clk);
        #1;
        check("load_busy", 64'(busy), 64'(1));
        do_reset();
        rand_kern();
        rand_pat();
        mac_lat = int'($urandom_range(1, 5));
        base = n_res;
        send_kernel();
        send_patch(N);
        wait_res(base + 1, 500);
        check("reload_k", 64'(kernel_loaded), 64'(1));

        repeat (5) @(negedge bus_clk);
        check("pairs_left", 64'(exp_pairs.size()), 64'(0));
        check("res_left", 64'(exp_res.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
